// File: rtl/win_banner_pkg.sv
// win_banner_pkg: shared types and ROM geometry for the win banner renderer
package win_banner_pkg;
  typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF, SOLID} banner_state_t;
  localparam int ROM_ROWS = 32;
  localparam int ROM_COLS = 64;
  localparam int ROM_AW = 5;
endpackage

// File: rtl/frame_tick_detect.sv
// frame_tick_detect: one-cycle pulse on each rising edge of a Clk-synchronous level
module frame_tick_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);
  logic frame_clk_q;
  always_ff @(posedge Clk) frame_clk_q <= Reset ? 1'b0 : frame_clk;
  assign tick = frame_clk & ~frame_clk_q;
endmodule

// File: rtl/win_banner_renderer.sv
// win_banner_renderer: maps VGA coordinates onto the win bitmap ROM and gates it with a blink/solid sequencer
module win_banner_renderer
  import win_banner_pkg::*;
#(
  parameter int ORIGIN_X     = 192,
  parameter int ORIGIN_Y     = 176,
  parameter int SCALE_SHIFT  = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_COUNT  = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              game_won,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [63:0]       rom_data,
  output logic              pixel_on,
  output logic              banner_active
);
  localparam int BANNER_W = ROM_COLS << SCALE_SHIFT;
  localparam int BANNER_H = ROM_ROWS << SCALE_SHIFT;
  localparam int CW = $clog2(ROM_COLS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int BW = $clog2(BLINK_COUNT + 1);
  banner_state_t state, state_n;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic tick, frame_end, in_box, in_box_q;
  logic [10:0] rel_x, rel_y;
  logic [CW-1:0] col_q;
  frame_tick_detect u_tick (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .tick(tick)
  );
  assign frame_end = tick && frame_cnt == FW'(BLINK_FRAMES - 1);
  assign banner_active = state != IDLE;
  // dropping game_won wins over any same-cycle tick
  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    blink_n = blink_cnt;
    if (!game_won) begin
      state_n = IDLE;
      frame_n = '0;
      blink_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLINK_ON;
          frame_n = '0;
          blink_n = '0;
        end
        BLINK_ON, BLINK_OFF: if (tick) begin
          frame_n = frame_end ? '0 : frame_cnt + 1'b1;
          if (frame_end && state == BLINK_ON) state_n = BLINK_OFF;
          if (frame_end && state == BLINK_OFF) begin
            blink_n = blink_cnt + 1'b1;
            state_n = blink_cnt == BW'(BLINK_COUNT - 1) ? SOLID : BLINK_ON;
          end
        end
        default: ;
      endcase
    end
  end
  // a negative offset sets bit 10, so screen positions left/above the origin never wrap into the box
  assign rel_x = {1'b0, DrawX} - 11'(ORIGIN_X);
  assign rel_y = {1'b0, DrawY} - 11'(ORIGIN_Y);
  assign in_box = !rel_x[10] && rel_x < 11'(BANNER_W) && !rel_y[10] && rel_y < 11'(BANNER_H);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      blink_cnt <= '0;
      rom_addr  <= '0;
      col_q     <= '0;
      in_box_q  <= 1'b0;
      pixel_on  <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      blink_cnt <= blink_n;
      rom_addr  <= in_box ? ROM_AW'(rel_y >> SCALE_SHIFT) : '0;
      col_q     <= CW'(rel_x >> SCALE_SHIFT);
      in_box_q  <= in_box;
      pixel_on  <= in_box_q && rom_data[CW'(ROM_COLS - 1) - col_q] && (state == BLINK_ON || state == SOLID);
    end
  end
endmodule
